// File: rtl/dht11_sensor_emulator_if.sv
// Register-side signals of the DHT11 emulator: frame bytes and controls in, status out.
// The single-wire bus stays a plain inout port on the emulator.
interface dht11_sensor_emulator_if;
    logic       enable;
    logic [7:0] humidity_int;
    logic [7:0] humidity_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       corrupt_checksum;
    logic       busy;
    logic       frame_done;

    modport master (
        output enable, humidity_int, humidity_dec, temp_int, temp_dec, corrupt_checksum,
        input  busy, frame_done
    );

    modport slave (
        input  enable, humidity_int, humidity_dec, temp_int, temp_dec, corrupt_checksum,
        output busy, frame_done
    );
endinterface

// File: rtl/dht11_sensor_emulator.sv
// DHT11 sensor emulator: waits for a host start pulse on the open-drain line, then
// plays the 80/80 us response and a 40-bit {hi,hd,ti,td,checksum} frame.
module dht11_sensor_emulator #(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30
) (
    input  logic                     clock,
    input  logic                     reset,
    inout  wire                      dht11,
    dht11_sensor_emulator_if.slave   bus
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE, MEASURE_LOW, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_sync;
    logic [PW-1:0] r_presc;
    logic [15:0] r_us_cnt;
    logic [39:0] r_shift;
    logic [5:0]  r_bit_idx;
    logic        r_drive_low, r_busy, r_frame_done;

    logic        w_bus_s, w_tick, w_phase_done;
    logic        w_drive_nxt, w_busy_nxt, w_done_nxt;
    logic [15:0] w_phase_len;
    logic [7:0]  w_sum, w_cs;

    assign w_bus_s = r_sync[1];
    assign w_tick  = (r_presc == PW'(DIV - 1));
    assign w_sum   = bus.humidity_int + bus.humidity_dec + bus.temp_int + bus.temp_dec;
    assign w_cs    = w_sum ^ {7'd0, bus.corrupt_checksum};

    // Sync resets high so a reset never looks like the start of a host low pulse.
    always_ff @(posedge clock) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], dht11};
    end

    always_ff @(posedge clock) begin
        if (reset || w_tick) r_presc <= '0;
        else                 r_presc <= r_presc + 1'b1;
    end

    always_comb begin
        w_phase_len = 16'd0;
        case (r_state)
            RESP_DELAY:          w_phase_len = 16'(RESP_DELAY_US);
            RESP_LOW, RESP_HIGH: w_phase_len = 16'd80;
            BIT_LOW, END_LOW:    w_phase_len = 16'd50;
            BIT_HIGH:            w_phase_len = r_shift[39] ? 16'd70 : 16'd26;
            default:             w_phase_len = 16'd0;
        endcase
    end

    // The counter restarts on every state change, so a phase ends on its N-th tick.
    assign w_phase_done = w_tick && (r_us_cnt >= w_phase_len - 16'd1);

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE:        if (bus.enable && !w_bus_s) w_state_nxt = MEASURE_LOW;
            MEASURE_LOW: if (w_bus_s)
                             w_state_nxt = (r_us_cnt >= 16'(START_MIN_US)) ? RESP_DELAY : IDLE;
            RESP_DELAY:  if (w_phase_done) w_state_nxt = RESP_LOW;
            RESP_LOW:    if (w_phase_done) w_state_nxt = RESP_HIGH;
            RESP_HIGH:   if (w_phase_done) w_state_nxt = BIT_LOW;
            BIT_LOW:     if (w_phase_done) w_state_nxt = BIT_HIGH;
            BIT_HIGH:    if (w_phase_done) w_state_nxt = (r_bit_idx == 6'd39) ? END_LOW : BIT_LOW;
            END_LOW:     if (w_phase_done) begin
                             w_state_nxt = IDLE;
                             w_done_nxt  = 1'b1;
                         end
            default:     w_state_nxt = IDLE;
        endcase
        w_drive_nxt = (w_state_nxt == RESP_LOW) || (w_state_nxt == BIT_LOW) ||
                      (w_state_nxt == END_LOW);
        w_busy_nxt  = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_us_cnt     <= 16'd0;
            r_shift      <= 40'd0;
            r_bit_idx    <= 6'd0;
            r_drive_low  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_drive_low  <= w_drive_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_done_nxt;

            if (w_state_nxt != r_state)
                r_us_cnt <= 16'd0;
            else if (r_state != IDLE && w_tick && r_us_cnt != 16'hFFFF)
                r_us_cnt <= r_us_cnt + 16'd1;

            // Bytes are captured once at acceptance; later input changes cannot reach the frame.
            if (r_state == MEASURE_LOW && w_state_nxt == RESP_DELAY) begin
                r_shift   <= {bus.humidity_int, bus.humidity_dec, bus.temp_int, bus.temp_dec, w_cs};
                r_bit_idx <= 6'd0;
            end else if (r_state == BIT_HIGH && w_phase_done) begin
                r_shift   <= {r_shift[38:0], 1'b0};
                r_bit_idx <= r_bit_idx + 6'd1;
            end
        end
    end

    assign dht11          = r_drive_low ? 1'b0 : 1'bz;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// Bench for the DHT11 emulator at 1 MHz (one tick per clock): a host drives start pulses,
// decodes the returned waveform and compares it with an arithmetic model of the frame.
module tb_dht11_sensor_emulator;
    logic clock = 1'b0;
    logic reset;
    logic host_low;
    wire  dht11;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    bit busy_seen = 0;

    assign dht11 = host_low ? 1'b0 : 1'bz;
    pullup (dht11);

    dht11_sensor_emulator_if ifc ();

    dht11_sensor_emulator #(
        .CLK_FREQ_HZ(1_000_000), .START_MIN_US(100), .RESP_DELAY_US(30)
    ) dut (
        .clock(clock), .reset(reset), .dht11(dht11), .bus(ifc.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ifc.frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        if (ifc.busy === 1'b1) busy_seen <= 1'b1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        checks++;
        assert ((d >= -tol && d <= tol) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    // Counts negedge samples before the line reaches lvl; returns budget on timeout.
    task automatic wait_level(input logic lvl, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clock);
            if (dht11 === lvl) break;
            n++;
        end
    endtask

    function automatic logic [39:0] model(input int hi, hd, ti, td, input int corr);
        int cs;
        cs = ((hi + hd + ti + td) % 256) ^ corr;
        return {8'(hi), 8'(hd), 8'(ti), 8'(td), 8'(cs)};
    endfunction

    task automatic host_start(input int low_us);
        @(posedge clock); #1 host_low = 1'b1;
        repeat (low_us) @(posedge clock);
        #1 host_low = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] hi, hd, ti, td, input logic corr,
                            input bit drop_en);
        logic [39:0] expf, got;
        int n, len, fd0, bad_lo, bad_hi, total, exp_total;
        ifc.humidity_int = hi; ifc.humidity_dec = hd;
        ifc.temp_int = ti;     ifc.temp_dec = td;
        ifc.corrupt_checksum = corr;
        expf = model(hi, hd, ti, td, int'(corr));
        fd0 = fd_cnt;
        host_start(150);
        wait_level(1'b0, 200, n);
        check_tol("gap", n, 33, 1);
        total = n;
        // Inputs now change under a frame already latched.
        ifc.humidity_int = 8'($urandom); ifc.humidity_dec = 8'($urandom);
        ifc.temp_int = 8'($urandom);     ifc.temp_dec = 8'($urandom);
        ifc.corrupt_checksum = ~corr;
        if (drop_en) ifc.enable = 1'b0;
        wait_level(1'b1, 200, n); check_tol("resp_low", n + 1, 80, 1);  total += n + 1;
        wait_level(1'b0, 200, n); check_tol("resp_high", n + 1, 80, 1); total += n + 1;
        bad_lo = 0; bad_hi = 0; got = '0;
        exp_total = 33 + 80 + 80 + 50;
        for (int i = 0; i < 40; i++) begin
            wait_level(1'b1, 200, n);
            if (n + 1 < 49 || n + 1 > 51) bad_lo++;
            total += n + 1;
            wait_level(1'b0, 200, n);
            len = n + 1;
            total += len;
            got = {got[38:0], (len > 48)};
            exp_total += 50 + (expf[39 - i] ? 70 : 26);
            if (len < (expf[39 - i] ? 69 : 25) || len > (expf[39 - i] ? 71 : 27)) bad_hi++;
        end
        wait_level(1'b1, 200, n); check_tol("end_low", n + 1, 50, 1); total += n + 1;
        for (int b = 0; b < 5; b++)
            check($sformatf("byte%0d", b), int'(got[39 - 8*b -: 8]), int'(expf[39 - 8*b -: 8]));
        check("bit_low_widths_bad", bad_lo, 0);
        check("bit_high_widths_bad", bad_hi, 0);
        check_tol("frame_total", total, exp_total, 4);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("frame_done_pulses", fd_cnt - fd0, 1);
        check("busy_after_frame", int'(ifc.busy), 0);
    endtask

    initial begin
        int n, fd0;
        reset = 1'b1; host_low = 1'b0;
        ifc.enable = 1'b1; ifc.corrupt_checksum = 1'b0;
        ifc.humidity_int = 8'd0; ifc.humidity_dec = 8'd0;
        ifc.temp_int = 8'd0; ifc.temp_dec = 8'd0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("reset_busy", int'(ifc.busy), 0);
        check("reset_frame_done", int'(ifc.frame_done), 0);
        check("reset_line", int'(dht11), 1);
        @(posedge clock); #1 reset = 1'b0;

        // Reference reading: 0x2D,0x00,0x1B,0x03 with checksum 0x4B.
        do_frame(8'd45, 8'd0, 8'd27, 8'd3, 1'b0, 0);
        do_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 0);
        do_frame(8'd45, 8'd0, 8'd27, 8'd3, 1'b1, 0);

        // Short host pulse: busy only while measuring, no response.
        fd0 = fd_cnt;
        @(posedge clock); #1 host_low = 1'b1;
        repeat (60) @(posedge clock);
        @(negedge clock);
        check("short_busy_measuring", int'(ifc.busy), 1);
        @(posedge clock); #1 host_low = 1'b0;
        wait_level(1'b0, 100, n);
        check("short_no_response", n, 100);
        check("short_busy_low", int'(ifc.busy), 0);
        check("short_no_done", fd_cnt - fd0, 0);

        for (int k = 0; k < 3; k++)
            do_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                     1'($urandom_range(0, 1)), 0);

        // Reset during the low phase of bit 12.
        fd0 = fd_cnt;
        host_start(150);
        wait_level(1'b0, 200, n);
        wait_level(1'b1, 200, n);
        wait_level(1'b0, 200, n);
        for (int i = 0; i < 12; i++) begin
            wait_level(1'b1, 200, n);
            wait_level(1'b0, 200, n);
        end
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_line_released", int'(dht11), 1);
        check("rst_busy", int'(ifc.busy), 0);
        @(posedge clock); #1 reset = 1'b0;
        wait_level(1'b0, 300, n);
        check("rst_line_stays_high", n, 300);
        check("rst_no_done", fd_cnt - fd0, 0);
        do_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);

        // Enable drops mid-frame: frame completes, then starts are ignored.
        do_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1);
        fd0 = fd_cnt;
        busy_seen = 0;
        host_start(150);
        wait_level(1'b0, 300, n);
        check("dis_no_response", n, 300);
        check("dis_no_busy", int'(busy_seen), 0);
        check("dis_no_done", fd_cnt - fd0, 0);
        ifc.enable = 1'b1;
        do_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
